uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UartTx handshake bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; the requester/UartTx side uses master.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    last;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      tx_data;
    logic               tx_we;
    logic               tx_ready;
    logic               busy;
    logic [2:0]         owner;
    logic               locked;

    modport slave (
        input  req, data, last, tx_ready,
        output ack, tx_data, tx_we, busy, owner, locked
    );

    modport master (
        output req, data, last, tx_ready,
        input  ack, tx_data, tx_we, busy, owner, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time from NREQ requesters into a UartTx.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until it issues a byte with last=1.
module uart_tx_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_arbiter_if.slave   bus
);
    localparam int unsigned OW = 3;

    typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            tx_we_q, tx_we_d;
    logic            busy_q, busy_d;
    logic            locked_q, locked_d;

    logic [NREQ-1:0] elig_c;
    logic            found_c;
    logic [OW-1:0]   win_c;
    logic [DW-1:0]   win_data_c;
    int unsigned     dist_c, best_c;

`ifdef UART_ARB_LOCK_EN
    logic            win_last_c;

    // While locked, only the current owner may be granted.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig_c[i] = bus.req[i] && (!locked_q || (owner_q == OW'(i)));
        end
    end
`else
    logic unused_last_c;

    assign elig_c        = bus.req;
    assign unused_last_c = ^bus.last;
`endif

    // Winner is the eligible requester closest after the pointer, wrapping at NREQ.
    always_comb begin
        found_c    = 1'b0;
        win_c      = '0;
        dist_c     = 0;
        best_c     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            dist_c = (i + NREQ - 1 - 32'(ptr_q)) % NREQ;
            if (elig_c[i] && (!found_c || (dist_c < best_c))) begin
                found_c = 1'b1;
                best_c  = dist_c;
                win_c   = OW'(i);
            end
        end
    end

    always_comb begin
        win_data_c = '0;
`ifdef UART_ARB_LOCK_EN
        win_last_c = 1'b0;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c == OW'(i)) begin
                win_data_c = bus.data[i*DW +: DW];
`ifdef UART_ARB_LOCK_EN
                win_last_c = bus.last[i];
`endif
            end
        end
    end

    // Next state; ack/tx_we are set on the IDLE->SEND edge so they are high only in SEND.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        locked_d  = locked_q;
        ack_d     = '0;
        tx_we_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_ready && found_c) begin
                    state_d   = SEND;
                    ptr_d     = win_c;
                    owner_d   = win_c;
                    tx_data_d = win_data_c;
                    ack_d     = NREQ'(1) << win_c;
                    tx_we_d   = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    locked_d  = !win_last_c;
`else
                    locked_d  = 1'b0;
`endif
                end
            end
            SEND:    state_d = HOLD;
            HOLD:    state_d = WAIT;
            WAIT:    if (bus.tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= OW'(NREQ - 1);
            owner_q   <= '0;
            tx_data_q <= '0;
            ack_q     <= '0;
            tx_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            tx_we_q   <= tx_we_d;
            busy_q    <= busy_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_we   = tx_we_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.locked  = locked_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants queued at stimulus time, checked on every tx_we.
// A small UartTx model drops tx_ready for three cycles after each write strobe.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    typedef struct packed {
        logic [2:0]    idx;
        logic [DW-1:0] dat;
        logic          lck;
    } exp_t;

    logic CLK;
    logic RST;
    logic ready_en;
    int   cnt;
    int   n_err;
    int   n_chk;
    exp_t sb_q[$];

    int         nbytes [NREQ];
    int         sent   [NREQ];
    logic [2:0] lastpat[NREQ];

    uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.tx_ready = ready_en && (cnt == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bval(input int i, input int k);
        return 8'(8'h61 + 16 * i + k);
    endfunction

    task automatic push_exp(input int idx, input int k, input logic lck);
        exp_t e;
        e.idx = 3'(idx);
        e.dat = bval(idx, k);
        e.lck = lck;
        sb_q.push_back(e);
    endtask

    // Scoreboard check on every strobe, ack silence elsewhere, and the UartTx ready model.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.tx_we) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("owner",   32'(bus.owner),   32'(e.idx));
                check("ack",     32'(bus.ack),     32'(4'(1) << e.idx));
                check("tx_data", 32'(bus.tx_data), 32'(e.dat));
                check("locked",  32'(bus.locked),  32'(e.lck));
            end
            cnt = 3;
        end else begin
            check("ack_quiet", 32'(bus.ack), 32'd0);
            if (cnt > 0) cnt = cnt - 1;
        end
    end

    task automatic do_reset();
        RST      = 1'b1;
        bus.req  = '0;
        bus.last = '0;
        bus.data = '0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Requesters hold req until acked, then present the next byte or withdraw.
    task automatic run_traffic(input int budget);
        int cyc;
        bit active;
        cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            sent[i] = 0;
            if (nbytes[i] > 0) begin
                bus.req[i]             = 1'b1;
                bus.data[i*DW +: DW]   = bval(i, 0);
                bus.last[i]            = lastpat[i][0];
            end
        end
        active = 1'b1;
        while (active && (cyc < budget)) begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    sent[i]++;
                    if (sent[i] >= nbytes[i]) begin
                        bus.req[i] = 1'b0;
                    end else begin
                        bus.data[i*DW +: DW] = bval(i, sent[i]);
                        bus.last[i]          = lastpat[i][sent[i]];
                    end
                end
            end
            active = (bus.req != '0) || (sb_q.size() != 0) || bus.busy;
        end
        check("traffic_done", 32'(active), 32'd0);
    endtask

    initial begin
        int  busy_cnt;
        bit  seen;
        n_err    = 0;
        n_chk    = 0;
        cnt      = 0;
        ready_en = 1'b1;
        do_reset();

        check("rst_tx_we",   32'(bus.tx_we),   32'd0);
        check("rst_ack",     32'(bus.ack),     32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_owner",   32'(bus.owner),   32'd0);
        check("rst_locked",  32'(bus.locked),  32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);

        // Single requester, one-cycle latency, busy length and tx_data hold.
        bus.req[0]    = 1'b1;
        bus.data[7:0] = 8'h61;
        push_exp(0, 0, 1'b0);
        @(negedge CLK);
        check("we_latency",  32'(bus.tx_we), 32'd1);
        check("ack_latency", 32'(bus.ack),   32'h1);
        bus.req       = '0;
        bus.data[7:0] = 8'hFF;
        busy_cnt = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!bus.busy) break;
            busy_cnt++;
        end
        check("busy_len",     32'(busy_cnt >= 4), 32'd1);
        check("tx_data_hold", 32'(bus.tx_data),   32'h61);

        // All four requesting: round-robin 0,1,2,3,0.
        do_reset();
        nbytes  = '{2, 1, 1, 1};
        lastpat = '{3'b111, 3'b111, 3'b111, 3'b111};
        push_exp(0, 0, 1'b0);
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        push_exp(3, 0, 1'b0);
        push_exp(0, 1, 1'b0);
        run_traffic(200);

        // tx_ready low keeps the arbiter idle; raising it grants on the next cycle.
        do_reset();
        ready_en       = 1'b0;
        bus.req        = 4'b0010;
        bus.data[15:8] = bval(1, 0);
        push_exp(1, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("idle_no_we", 32'(bus.tx_we), 32'd0);
        end
        check("idle_busy", 32'(bus.busy), 32'd0);
        ready_en = 1'b1;
        @(negedge CLK);
        check("ready_we",  32'(bus.tx_we), 32'd1);
        check("ready_ack", 32'(bus.ack),   32'h2);
        bus.req = '0;
        repeat (8) @(negedge CLK);

        // Requester 2 sends a 3-byte packet while requester 1 competes.
        do_reset();
        nbytes  = '{0, 3, 3, 0};
        lastpat = '{3'b111, 3'b111, 3'b100, 3'b111};
`ifdef UART_ARB_LOCK_EN
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b1);
        push_exp(2, 1, 1'b1);
        push_exp(2, 2, 1'b0);
        push_exp(1, 1, 1'b0);
        push_exp(1, 2, 1'b0);
`else
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        push_exp(1, 1, 1'b0);
        push_exp(2, 1, 1'b0);
        push_exp(1, 2, 1'b0);
        push_exp(2, 2, 1'b0);
`endif
        run_traffic(300);

        // Reset during SEND aborts the grant and restores the pointer.
        do_reset();
        nbytes  = '{1, 1, 1, 1};
        lastpat = '{3'b111, 3'b111, 3'b111, 3'b111};
        for (int i = 0; i < NREQ; i++) bus.data[i*DW +: DW] = bval(i, 0);
        bus.req  = 4'b1111;
        bus.last = 4'b1111;
        push_exp(0, 0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (bus.tx_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("send_seen", 32'(seen), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_send_we",    32'(bus.tx_we), 32'd0);
        check("rst_send_ack",   32'(bus.ack),   32'd0);
        check("rst_send_busy",  32'(bus.busy),  32'd0);
        check("rst_send_owner", 32'(bus.owner), 32'd0);
        push_exp(0, 0, 1'b0);
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        push_exp(3, 0, 1'b0);
        run_traffic(200);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
